// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp encodings, 4-bit ALU control codes, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

   // Main-decoder ALUOp encodings
   localparam logic [1:0] ALUOP_LS = 2'b00;   // load/store address add
   localparam logic [1:0] ALUOP_BR = 2'b01;   // branch compare subtract
   localparam logic [1:0] ALUOP_R  = 2'b10;   // R-type, funct fields decide
   localparam logic [1:0] ALUOP_I  = 2'b11;   // I-type, funct3 decides

   // ALU control codes
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SLTU = 4'b1100;
   localparam logic [3:0] ALU_MUL  = 4'b1101;

   // funct7 value marking the multiply/divide extension group
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Execution FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: ALUOp/funct3/funct7 -> 4-bit ALU control code.
// Latency: purely combinational.
// Backpressure: none, no state.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output logic [3:0] o_alu_ctrl
);

   logic [3:0] w_rtype_ctrl;

   // funct3 table shared by R-type and I-type; funct7[5] picks SUB and SRA
   always_comb begin
      w_rtype_ctrl = ALU_ADD;
      case (i_funct3)
         3'b000:  w_rtype_ctrl = i_funct7[5] ? ALU_SUB : ALU_ADD;
         3'b001:  w_rtype_ctrl = ALU_SLL;
         3'b010:  w_rtype_ctrl = ALU_SLT;
         3'b011:  w_rtype_ctrl = ALU_SLTU;
         3'b100:  w_rtype_ctrl = ALU_XOR;
         3'b101:  w_rtype_ctrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  w_rtype_ctrl = ALU_OR;
         default: w_rtype_ctrl = ALU_AND;
      endcase
   end

   // Top-level decode: fixed ops for LS/BR, MUL group only for R-type,
   // and I-type never subtracts (no funct7 on an add-immediate)
   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_alu_op)
         ALUOP_LS: o_alu_ctrl = ALU_ADD;
         ALUOP_BR: o_alu_ctrl = ALU_SUB;
         ALUOP_R: begin
            if (i_funct7 == FUNCT7_MULDIV)
               o_alu_ctrl = (i_funct3 == 3'b000) ? ALU_MUL : ALU_ADD;
            else
               o_alu_ctrl = w_rtype_ctrl;
         end
         default: begin
            if (i_funct3 == 3'b000)
               o_alu_ctrl = ALU_ADD;
            else
               o_alu_ctrl = w_rtype_ctrl;
         end
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ops plus a WIDTH-step shift-add multiplier.
// Latency: 1 cycle for ALU ops, WIDTH+1 cycles for MUL (no early exit).
// Backpressure: result held in HOLD until out_ready; in_ready low in MULT and stalled HOLD.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       ALUOp,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   // count spans 0..WIDTH, one extra bit keeps WIDTH representable
   localparam int                 CNT_W    = SHAMT_W + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_out_valid;
   logic               r_busy;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CNT_W-1:0]   r_count;

   logic [3:0]         w_alu_ctrl;
   logic [WIDTH-1:0]   w_alu_res;
   logic [SHAMT_W-1:0] w_shamt;
   logic               w_is_mul;
   logic               w_in_ready;
   logic               w_accept;
   logic [WIDTH-1:0]   w_acc_next;

   alu_ctrl_dec u_dec (
      .i_alu_op   (ALUOp),
      .i_funct3   (funct3),
      .i_funct7   (funct7),
      .o_alu_ctrl (w_alu_ctrl)
   );

   assign w_shamt    = b[SHAMT_W-1:0];
   assign w_is_mul   = (w_alu_ctrl == ALU_MUL);
   // HOLD frees the slot in the same cycle the consumer takes the result
   assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign busy      = r_busy;

   // Single-cycle ALU datapath; MUL is produced by the iterative path instead
   always_comb begin
      w_alu_res = '0;
      case (w_alu_ctrl)
         ALU_AND:  w_alu_res = a & b;
         ALU_OR:   w_alu_res = a | b;
         ALU_ADD:  w_alu_res = a + b;
         ALU_SUB:  w_alu_res = a - b;
         ALU_XOR:  w_alu_res = a ^ b;
         ALU_SLL:  w_alu_res = a << w_shamt;
         ALU_SRL:  w_alu_res = a >> w_shamt;
         ALU_SRA:  w_alu_res = $unsigned($signed(a) >>> w_shamt);
         ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default:  w_alu_res = '0;
      endcase
   end

   // Control FSM with registered result/zero/out_valid/busy; reset wins over any handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_count     <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_mcand     <= a;
                     r_mplier    <= b;
                     r_acc       <= '0;
                     r_count     <= '0;
                     r_state     <= ST_MULT;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b1;
                  end else begin
                     r_result    <= w_alu_res;
                     r_zero      <= (w_alu_res == '0);
                     r_state     <= ST_HOLD;
                     r_out_valid <= 1'b1;
                  end
               end else if ((r_state == ST_HOLD) && out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            ST_MULT: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (r_count == CNT_LAST) begin
                  r_result    <= w_acc_next;
                  r_zero      <= (w_acc_next == '0);
                  r_state     <= ST_HOLD;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit at WIDTH=32 and WIDTH=8 side by side.
// Directed vector table, random ops against a behavioural model, and
// hand sequences for backpressure, back-to-back issue and reset aborts.
module tb_alu_exec_unit;

   localparam int K_ADD = 0, K_SUB = 1, K_MUL = 2, K_SLL = 3, K_SRL = 4, K_SRA = 5,
                  K_SLT = 6, K_SLTU = 7, K_XOR = 8, K_OR = 9, K_AND = 10;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic        sel;          // 0 drives the 32-bit unit, 1 drives the 8-bit unit
   logic [1:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [63:0] ta;
   logic [63:0] tb_b;

   logic        rdy32, ov32, z32, busy32;
   logic [31:0] res32;
   logic        rdy8, ov8, z8, busy8;
   logic [7:0]  res8;

   logic [63:0] g_res;
   logic        g_ov, g_z, g_busy, g_rdy;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(rdy32),
      .ALUOp(op), .funct3(f3), .funct7(f7), .a(ta[31:0]), .b(tb_b[31:0]),
      .out_valid(ov32), .out_ready(out_ready), .result(res32), .zero(z32), .busy(busy32)
   );

   alu_exec_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(rdy8),
      .ALUOp(op), .funct3(f3), .funct7(f7), .a(ta[7:0]), .b(tb_b[7:0]),
      .out_valid(ov8), .out_ready(out_ready), .result(res8), .zero(z8), .busy(busy8)
   );

   assign g_res  = sel ? {56'd0, res8} : {32'd0, res32};
   assign g_ov   = sel ? ov8   : ov32;
   assign g_z    = sel ? z8    : z32;
   assign g_busy = sel ? busy8 : busy32;
   assign g_rdy  = sel ? rdy8  : rdy32;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic longint sext(input logic [63:0] v, input int w);
      longint t;
      t = longint'(v << (64 - w));
      return t >>> (64 - w);
   endfunction

   // Behavioural reference: operation chosen from the decode rules, value by plain arithmetic
   function automatic void ref_model(input logic [1:0] o, input logic [2:0] x3, input logic [6:0] x7,
                                     input logic [63:0] va, input logic [63:0] vb, input int w,
                                     output logic [63:0] r, output bit mul);
      logic [63:0] m, am, bm;
      longint      sa, sb;
      int          sh, k;
      m  = (64'd1 << w) - 64'd1;
      am = va & m;
      bm = vb & m;
      sa = sext(am, w);
      sb = sext(bm, w);
      sh = int'(vb % 64'(w));
      if (o == 2'b00)                        k = K_ADD;
      else if (o == 2'b01)                   k = K_SUB;
      else if (o == 2'b10 && x7 == 7'h01)    k = (x3 == 3'd0) ? K_MUL : K_ADD;
      else begin
         case (x3)
            3'd0:    k = (o == 2'b10 && x7[5]) ? K_SUB : K_ADD;
            3'd1:    k = K_SLL;
            3'd2:    k = K_SLT;
            3'd3:    k = K_SLTU;
            3'd4:    k = K_XOR;
            3'd5:    k = x7[5] ? K_SRA : K_SRL;
            3'd6:    k = K_OR;
            default: k = K_AND;
         endcase
      end
      mul = (k == K_MUL);
      case (k)
         K_ADD:   r = am + bm;
         K_SUB:   r = am - bm;
         K_MUL:   r = am * bm;
         K_SLL:   r = am << sh;
         K_SRL:   r = am >> sh;
         K_SRA:   r = 64'(sa >>> sh);
         K_SLT:   r = (sa < sb) ? 64'd1 : 64'd0;
         K_SLTU:  r = (am < bm) ? 64'd1 : 64'd0;
         K_XOR:   r = am ^ bm;
         K_OR:    r = am | bm;
         default: r = am & bm;
      endcase
      r = r & m;
   endfunction

   // Issue one op from an idle unit with out_ready=1; returns result, cycles to out_valid, busy cycles
   task automatic run_op(input logic [1:0] o, input logic [2:0] x3, input logic [6:0] x7,
                         input logic [63:0] va, input logic [63:0] vb,
                         output logic [63:0] r, output logic z, output int lat, output int bcnt);
      op = o; f3 = x3; f7 = x7; ta = va; tb_b = vb;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat  = 1;
      bcnt = 0;
      while (!g_ov && lat < 200) begin
         if (g_busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      r = g_res;
      z = g_z;
      @(negedge clk);
   endtask

   typedef struct {
      string       name;
      bit          s;
      logic [1:0]  o;
      logic [2:0]  x3;
      logic [6:0]  x7;
      logic [63:0] va;
      logic [63:0] vb;
      logic [63:0] res;
      logic        z;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input bit s, input logic [1:0] o, input logic [2:0] x3,
                      input logic [6:0] x7, input logic [63:0] va, input logic [63:0] vb,
                      input logic [63:0] res, input logic z, input int lat);
      vec_t v;
      v.name = n; v.s = s; v.o = o; v.x3 = x3; v.x7 = x7;
      v.va = va; v.vb = vb; v.res = res; v.z = z; v.lat = lat;
      vecs.push_back(v);
   endtask

   initial begin
      logic [63:0] r, er, hold_val;
      logic        z;
      int          lat, bcnt, seen;
      bit          mul;
      int          w;

      add("sub32",      0, 2'b10, 3'd0, 7'h20, 64'd5,          64'd7,  64'hFFFFFFFE, 0, 1);
      add("sub8",       1, 2'b10, 3'd0, 7'h20, 64'd5,          64'd7,  64'hFE,       0, 1);
      add("mul32",      0, 2'b10, 3'd0, 7'h01, 64'hFFFFFFFF,   64'd3,  64'hFFFFFFFD, 0, 33);
      add("mul8",       1, 2'b10, 3'd0, 7'h01, 64'hFF,         64'd3,  64'hFD,       0, 9);
      add("sra32",      0, 2'b11, 3'd5, 7'h20, 64'h80000000,   64'd4,  64'hF8000000, 0, 1);
      add("srl32",      0, 2'b11, 3'd5, 7'h00, 64'h80000000,   64'd4,  64'h08000000, 0, 1);
      add("sra8",       1, 2'b11, 3'd5, 7'h20, 64'h80,         64'd4,  64'hF8,       0, 1);
      add("srl8",       1, 2'b11, 3'd5, 7'h00, 64'h80,         64'd4,  64'h08,       0, 1);
      add("slt32",      0, 2'b10, 3'd2, 7'h00, 64'hFFFFFFFF,   64'd1,  64'd1,        0, 1);
      add("sltu32",     0, 2'b10, 3'd3, 7'h00, 64'hFFFFFFFF,   64'd1,  64'd0,        1, 1);
      add("slt8",       1, 2'b10, 3'd2, 7'h00, 64'hFF,         64'd1,  64'd1,        0, 1);
      add("sltu8",      1, 2'b10, 3'd3, 7'h00, 64'hFF,         64'd1,  64'd0,        1, 1);
      add("ls_add_ovf", 0, 2'b00, 3'd5, 7'h20, 64'hFFFFFFFF,   64'd1,  64'd0,        1, 1);
      add("br_sub",     0, 2'b01, 3'd7, 7'h01, 64'd10,         64'd3,  64'd7,        0, 1);
      add("r_m_add",    0, 2'b10, 3'd3, 7'h01, 64'd10,         64'd3,  64'd13,       0, 1);
      add("i_add_f7",   0, 2'b11, 3'd0, 7'h20, 64'd10,         64'd3,  64'd13,       0, 1);
      add("i_no_mul",   0, 2'b11, 3'd0, 7'h01, 64'd2,          64'd3,  64'd5,        0, 1);
      add("sll32_mask", 0, 2'b10, 3'd1, 7'h00, 64'd1,          64'h21, 64'd2,        0, 1);
      add("sll8_mask",  1, 2'b10, 3'd1, 7'h00, 64'd1,          64'h09, 64'd2,        0, 1);
      add("mul8_ovf",   1, 2'b10, 3'd0, 7'h01, 64'h10,         64'h10, 64'd0,        1, 9);
      add("xor32",      0, 2'b11, 3'd4, 7'h00, 64'hF0F0,       64'hFF00, 64'h0FF0,   0, 1);

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
      op = '0; f3 = '0; f7 = '0; ta = '0; tb_b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state of both widths
      chk("rst_ov32",  {63'd0, ov32},   64'd0);
      chk("rst_busy32",{63'd0, busy32}, 64'd0);
      chk("rst_rdy32", {63'd0, rdy32},  64'd1);
      chk("rst_res32", {32'd0, res32},  64'd0);
      chk("rst_z32",   {63'd0, z32},    64'd0);
      chk("rst_ov8",   {63'd0, ov8},    64'd0);
      chk("rst_res8",  {56'd0, res8},   64'd0);

      // Directed table
      foreach (vecs[i]) begin
         sel = vecs[i].s;
         run_op(vecs[i].o, vecs[i].x3, vecs[i].x7, vecs[i].va, vecs[i].vb, r, z, lat, bcnt);
         chk({vecs[i].name, "_res"},  r, vecs[i].res);
         chk({vecs[i].name, "_zero"}, {63'd0, z}, {63'd0, vecs[i].z});
         chk({vecs[i].name, "_lat"},  64'(lat), 64'(vecs[i].lat));
         chk({vecs[i].name, "_busy"}, 64'(bcnt), 64'(vecs[i].lat - 1));
      end

      // Random ops against the reference model
      for (int i = 0; i < 80; i++) begin
         logic [63:0] va, vb;
         logic [6:0]  x7;
         int          pick;
         sel  = i[0];
         w    = sel ? 8 : 32;
         va   = {$urandom, $urandom};
         vb   = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) vb = va;
         pick = $urandom_range(0, 3);
         x7   = (pick == 0) ? 7'h00 : (pick == 1) ? 7'h20 : (pick == 2) ? 7'h01 : 7'($urandom);
         op   = 2'($urandom);
         f3   = 3'($urandom);
         ref_model(op, f3, x7, va, vb, w, er, mul);
         run_op(op, f3, x7, va, vb, r, z, lat, bcnt);
         chk("rnd_res",  r, er);
         chk("rnd_zero", {63'd0, z}, {63'd0, (er == 64'd0)});
         chk("rnd_lat",  64'(lat), mul ? 64'(w + 1) : 64'd1);
      end

      // Stalled HOLD, then back-to-back accept as the result drains
      sel = 1'b0;
      op = 2'b00; f3 = 3'd0; f7 = 7'h00; ta = 64'd10; tb_b = 64'd20;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_ov", {63'd0, g_ov}, 64'd1);
      chk("hold_res0", g_res, 64'd30);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_res", g_res, 64'd30);
         chk("hold_rdy", {63'd0, g_rdy}, 64'd0);
         chk("hold_ov_stay", {63'd0, g_ov}, 64'd1);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op = 2'b10; f3 = 3'd7; f7 = 7'h00; ta = 64'hF0; tb_b = 64'h0F;
      #1;
      chk("b2b_rdy", {63'd0, g_rdy}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_ov",   {63'd0, g_ov}, 64'd1);
      chk("b2b_res",  g_res, 64'd0);
      chk("b2b_zero", {63'd0, g_z}, 64'd1);
      @(negedge clk);
      chk("drain_ov", {63'd0, g_ov}, 64'd0);

      // Reset in the middle of a multiply, with a competing request on the same edge
      run_op(2'b00, 3'd0, 7'h00, 64'd1, 64'd1, r, z, lat, bcnt);
      chk("pre_res", r, 64'd2);
      op = 2'b10; f3 = 3'd0; f7 = 7'h01; ta = 64'd7; tb_b = 64'd9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("mul_busy_mid", {63'd0, g_busy}, 64'd1);
      reset = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      chk("abort_ov",   {63'd0, g_ov},   64'd0);
      chk("abort_busy", {63'd0, g_busy}, 64'd0);
      chk("abort_res",  g_res,           64'd0);
      chk("abort_rdy",  {63'd0, g_rdy},  64'd1);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (g_ov || g_busy) seen++;
      end
      chk("abort_quiet", 64'(seen), 64'd0);

      // Reset during a stalled HOLD on the 8-bit unit discards the result
      sel = 1'b1;
      op = 2'b00; f3 = 3'd0; f7 = 7'h00; ta = 64'd3; tb_b = 64'd4;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      hold_val = g_res;
      chk("hold8_res", hold_val, 64'd7);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("hold8_abort_ov",  {63'd0, g_ov}, 64'd0);
      chk("hold8_abort_res", g_res, 64'd0);
      out_ready = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
- REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
- REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
- REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port in_valid  input  1  operation request valid.
- REQ-006 SHALL have port in_ready  output  1  unit accepts request this cycle.
- REQ-007 SHALL have port ALUOp  input  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type.
- REQ-008 SHALL have port funct3  input  3  instruction funct3.
- REQ-009 SHALL have port funct7  input  7  instruction funct7 (full field).
- REQ-010 SHALL have port a  input  WIDTH  operand A.
- REQ-011 SHALL have port b  input  WIDTH  operand B (or immediate).
- REQ-012 SHALL have port out_valid  output  1  result valid.
- REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
- REQ-014 SHALL have port result  output  WIDTH  registered result.
- REQ-015 SHALL have port zero  output  1  registered (result == 0).
- REQ-016 SHALL have port busy  output  1  high while multiply in progress.

Function
- REQ-017 Decode SHALL map to 4-bit codes: AND 0000, OR 0001, ADD 0010, SUB 0110, XOR 0111, SLL 1000, SRL 1001, SRA 1010, SLT 1011, SLTU 1100, MUL 1101.
- REQ-018 ALUOp 00 -> ADD; 01 -> SUB, regardless of funct fields.
- REQ-019 ALUOp 10, funct7=0000001, funct3=000 -> MUL; funct7=0000001 with any other funct3 -> ADD.
- REQ-020 ALUOp 10, funct3: 000 -> SUB if funct7[5] else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7[5] else SRL; 110 OR; 111 AND.
- REQ-021 ALUOp 11 SHALL decode as REQ-020 except funct3=000 always ADD; funct7[5] only selects SRA for funct3=101.
- REQ-022 Shifts SHALL use b[SHAMT_W-1:0]; SLT signed, SLTU unsigned compare, result zero-extended 0/1.
- REQ-023 ADD/SUB/MUL SHALL return low WIDTH bits, overflow discarded.
- REQ-024 FSM states: IDLE, MULT, HOLD.
- REQ-025 IDLE: in_ready=1; on in_valid with non-MUL op, result/zero registered, go HOLD (latency 1 cycle).
- REQ-026 IDLE: on in_valid with MUL, load multiplicand=a, multiplier=b, acc=0, count=0, go MULT.
- REQ-027 MULT: each cycle acc += multiplicand if multiplier[0]; multiplicand <<= 1; multiplier >>= 1; count++; after exactly WIDTH cycles write acc to result, go HOLD (MUL latency WIDTH+1 cycles, no early exit).
- REQ-028 MULT: in_ready=0, busy=1, out_valid=0; operand inputs ignored.
- REQ-029 HOLD: out_valid=1, result/zero stable until out_valid&&out_ready.
- REQ-030 HOLD with out_ready=1: in_ready=1; simultaneous in_valid SHALL be accepted as in IDLE (back-to-back, no bubble); without in_valid go IDLE.
- REQ-031 HOLD with out_ready=0: in_ready=0, state held indefinitely.
- REQ-032 out_valid SHALL never be high in IDLE or MULT.

Reset
- REQ-033 reset high at clk edge: state IDLE, result 0, zero 0, out_valid 0, busy 0, acc/count 0.
- REQ-034 reset SHALL abort an in-progress MULT or HOLD; pending result discarded, no out_valid after reset.
- REQ-035 reset SHALL take priority over all handshake events in the same cycle.

Structure
- REQ-036 Shared package alu_pkg SHALL hold ALUOp codes, 4-bit ALU control codes, FSM state enum.
- REQ-037 Combinational decode (REQ-017..021) SHALL be sub-module alu_ctrl_dec; datapath and FSM in alu_exec_unit.

Verification
- REQ-038 ALUOp=10, funct3=000, funct7=0100000, a=5, b=7, out_ready=1 -> one cycle later out_valid=1, result=0xFFFFFFFE, zero=0.
- REQ-039 ALUOp=10, funct7=0000001, funct3=000, a=0xFFFFFFFF, b=3 -> busy 32 cycles, out_valid cycle 33, result=0xFFFFFFFD.
- REQ-040 ALUOp=11, funct3=101, funct7=0100000, a=0x80000000, b=4 -> result=0xF8000000; funct7=0 -> 0x08000000.
- REQ-041 Result in HOLD, out_ready=0 for 5 cycles -> result stable, in_ready=0; then out_ready=1 with in_valid AND a=0xF0,b=0x0F -> next cycle result=0, zero=1.
- REQ-042 reset asserted at MULT cycle 10 -> next cycle IDLE, out_valid=0, busy=0, result=0.
- REQ-043 ALUOp=10, funct3=010 vs 011, a=0xFFFFFFFF, b=1 -> SLT result=1, SLTU result=0; repeat 38-43 with WIDTH=8.
